// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory controller for the pipeline M stage. Accepts one load/store
//   at a time, stalls the pipeline for LATENCY cycles, then pulses done (and
//   err for illegal accesses) for one cycle. Storage is an internal array of
//   DEPTH words of DATA_W bits, organised as one byte-wide array per lane so
//   that partial stores touch only their own lanes.
//
// Parameters
//   DATA_W   data bus width in bits (multiple of 8, >= 32)
//   DEPTH    number of DATA_W-bit words
//   LATENCY  cycles from acceptance to completion (1..8)
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   req      access request (sampled in IDLE only)
//   we       1 = store, 0 = load
//   size     00 byte, 01 halfword, 10 word (full DATA_W), 11 reserved
//   addr     byte address
//   wdata    store data, right-aligned for byte/halfword
//   rdata    registered load result, zero-extended
//   stall    pipeline hold request
//   done     one-cycle completion pulse
//   err      one-cycle error pulse, coincident with done
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = 32 - LB;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_err;

    logic              w_req_ok;
    logic              w_accept;
    logic              w_enter_done;
    logic              w_op_we;
    logic [1:0]        w_op_size;
    logic [31:0]       w_op_addr;
    logic [DATA_W-1:0] w_op_wdata;
    logic [LB-1:0]     w_lane;
    logic [IW-1:0]     w_index;
    logic [AW-1:0]     w_idx;
    logic              w_err;
    logic              w_mem_we;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_shift;
    logic [DATA_W-1:0] w_rd_val;

    // A request is never taken while reset is held, even if req is high.
    assign w_req_ok = req & reset;
    assign w_accept = (r_state == S_IDLE) && w_req_ok;

    // With LATENCY=1 the access completes on the acceptance edge itself, so
    // the operation is taken straight from the inputs while in IDLE and from
    // the captured copy afterwards.
    assign w_op_we    = (r_state == S_IDLE) ? we    : r_we;
    assign w_op_size  = (r_state == S_IDLE) ? size  : r_size;
    assign w_op_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

    assign w_lane  = w_op_addr[LB-1:0];
    assign w_index = w_op_addr[31:LB];
    assign w_idx   = w_index[AW-1:0];

    assign w_err = (w_op_size == 2'b11)
                || ((w_op_size == 2'b01) && w_lane[0])
                || ((w_op_size == 2'b10) && (w_lane != '0))
                || (32'(w_index) >= 32'(DEPTH));

    assign w_enter_done = (w_accept && (LATENCY == 1))
                       || ((r_state == S_BUSY) && (r_cnt == 3'd0));

    assign w_mem_we = w_enter_done && w_op_we && !w_err;

    always_comb begin
        w_be = '1;
        case (w_op_size)
            2'b00:   w_be = NB'(1) << w_lane;
            2'b01:   w_be = NB'(3) << w_lane;
            default: w_be = '1;
        endcase
    end

    assign w_wr_data  = w_op_wdata << {w_lane, 3'b000};
    assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_rd_val = w_rd_shift;
        case (w_op_size)
            2'b00:   w_rd_val = DATA_W'(w_rd_shift[7:0]);
            2'b01:   w_rd_val = DATA_W'(w_rd_shift[15:0]);
            default: w_rd_val = w_rd_shift;
        endcase
    end

    // One byte-wide array per lane; contents are not reset.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_mem_we && w_be[gi]) begin
                    r_mem[w_idx] <= w_wr_data[gi*8 +: 8];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_mem[w_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_enter_done;
            r_err  <= w_enter_done && w_err;

            // Errors clear rdata; valid loads replace it; stores keep it.
            if (w_enter_done) begin
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!w_op_we) begin
                    r_rdata <= w_rd_val;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= we;
                        r_size  <= size;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (LATENCY == 1) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall = w_accept || (r_state == S_BUSY);
    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int NBY   = 4;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    logic        req_b;
    logic [31:0] rdata_l1, rdata_l8;
    logic        stall_l1, done_l1, err_l1;
    logic        stall_l8, done_l8, err_l8;

    data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .err(err)
    );

    data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req_b), .we(1'b0), .size(2'b10),
        .addr(32'h0), .wdata(32'h0), .rdata(rdata_l1), .stall(stall_l1),
        .done(done_l1), .err(err_l1)
    );

    data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(8)) u_lat8 (
        .clk(clk), .reset(reset), .req(req_b), .we(1'b0), .size(2'b10),
        .addr(32'h0), .wdata(32'h0), .rdata(rdata_l8), .stall(stall_l8),
        .done(done_l8), .err(err_l8)
    );

    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model: flat byte-addressed memory plus the last rdata value.
    logic [7:0]  m_mem [DEPTH*NBY];
    logic [31:0] m_rdata = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One complete access on the LATENCY=2 instance, checked cycle by cycle.
    task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic poke);
        logic        e;
        int          nbytes;
        logic [31:0] v;
        nbytes = 1 << sz;
        e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
            || ((a / NBY) >= DEPTH);
        if (e) begin
            m_rdata = 32'h0;
        end else if (w) begin
            for (int b = 0; b < nbytes; b++) m_mem[a + b] = wd[8*b +: 8];
        end else begin
            v = 32'h0;
            for (int b = 0; b < nbytes; b++) v |= 32'(m_mem[a + b]) << (8 * b);
            m_rdata = v;
        end

        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        #1;
        check_val("acc_stall", 32'(stall), 32'd1);
        check_val("acc_done", 32'(done), 32'd0);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            req = 1'b0;
            we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
            #1;
            check_val("busy_stall", 32'(stall), 32'd1);
            check_val("busy_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("done_stall", 32'(stall), 32'd0);
        check_val("done_err", 32'(err), 32'(e));
        check_val("done_rdata", rdata, m_rdata);
        // A request shown in DONE must be dropped; a junk store here would
        // corrupt memory or shift the next access if it were taken.
        if (poke) begin
            req = 1'b1; we = 1'b1; size = 2'b10; addr = a & 32'hFC; wdata = $urandom;
        end
        $display("txn we=%0d size=%0d addr=%08h wdata=%08h rdata=%08h err=%0d",
                 w, sz, a, wd, rdata, err);
    endtask

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        int          cnt_d1, cnt_s1, cnt_d8, cnt_s8, last1, last8;

        reset = 1'b0; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_rdata", rdata, 32'h0);
        req = 1'b0;
        reset = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) access(1'b1, 2'b10, 32'(i * 4), $urandom, 1'b0);

        access(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
        check_val("scn_word", rdata, 32'hDEADBEEF);
        access(1'b1, 2'b00, 32'h12, 32'h00000055, 1'b0);
        access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
        check_val("scn_merge", rdata, 32'hDE55BEEF);
        access(1'b0, 2'b00, 32'h13, 32'h0, 1'b0);
        check_val("scn_byte", rdata, 32'h000000DE);
        access(1'b0, 2'b01, 32'h11, 32'h0, 1'b0);
        access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
        check_val("scn_nocorrupt", rdata, 32'hDE55BEEF);
        access(1'b1, 2'b10, 32'h100, 32'hCAFEF00D, 1'b0);
        access(1'b0, 2'b10, 32'h0, 32'h0, 1'b0);

        // Reset during BUSY aborts a store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        m_rdata = 32'h0;
        #1;
        check_val("abort_stall", 32'(stall), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_err", 32'(err), 32'd0);
        check_val("abort_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_val("abort_idle_done", 32'(done), 32'd0);
        check_val("abort_idle_stall", 32'(stall), 32'd0);
        access(1'b0, 2'b10, 32'h20, 32'h0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 7);
            if (r == 0) a = $urandom_range(DEPTH * NBY, DEPTH * NBY + 255);
            else        a = $urandom_range(0, DEPTH * NBY - 1);
            if (r != 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            access(w, sz, a, $urandom, ($urandom_range(0, 3) == 0));
        end

        // Back-to-back requests on the LATENCY=1 and LATENCY=8 instances.
        @(negedge clk);
        req = 1'b0;
        req_b = 1'b1;
        cnt_d1 = 0; cnt_s1 = 0; cnt_d8 = 0; cnt_s8 = 0; last1 = -1; last8 = -1;
        for (int c = 0; c < 72; c++) begin
            #1;
            if (done_l1) begin
                if (last1 >= 0) check_val("l1_gap", 32'(c - last1), 32'd2);
                last1 = c; cnt_d1++;
            end
            if (done_l8) begin
                if (last8 >= 0) check_val("l8_gap", 32'(c - last8), 32'd9);
                last8 = c; cnt_d8++;
            end
            if (stall_l1) cnt_s1++;
            if (stall_l8) cnt_s8++;
            @(negedge clk);
        end
        req_b = 1'b0;
        check_val("l1_dones", 32'(cnt_d1), 32'd36);
        check_val("l1_stalls", 32'(cnt_s1), 32'd36);
        check_val("l8_dones", 32'(cnt_d8), 32'd8);
        check_val("l8_stalls", 32'(cnt_s8), 32'd64);
        check_val("l8_first_done", 32'(last8), 32'd71);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
